// File: rtl/demux1to4096_wr_n.sv
// demux1to4096_wr_n: 4096-entry x n-bit register array with one handshaked
// write port. The write address is decoded in two levels (64 groups x 64
// entries) across a two-stage pipeline. Every entry is presented in parallel
// on data_o.
// Optional bulk clear is compiled in with `define DEMUX_WR_CLEAR_EN. It sweeps
// one 64-entry group per cycle. Without the macro, clr_i is ignored,
// busy_o is 0 and wr_ready_o is 1.
module demux1to4096_wr_n #(
  parameter int n       = 4,
  parameter int address = 12
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [address-1:0] wr_addr_i,
  input  logic [n-1:0]       wr_data_i,
  output logic               wr_done_o,
  input  logic               clr_i,
  output logic               busy_o,
  output logic [n-1:0]       data_o [0:4095]
);

  localparam int ENTRIES = 4096;

  logic        accept;
  logic [63:0] s1_grp;
  logic [5:0]  s1_idx;
  logic [n-1:0] s1_data;
  logic        s1_v;
  logic [63:0] clr_grp;

  assign accept = wr_valid_i && wr_ready_o;

`ifdef DEMUX_WR_CLEAR_EN
  // state | meaning
  // IDLE  | accepting writes; clr_i starts a sweep
  // CLEAR | zeroing group gcnt each cycle, writes held off
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state, state_d;
  logic [5:0] gcnt, gcnt_d;

  // FSM state and sweep counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      gcnt  <= '0;
    end else begin
      state <= state_d;
      gcnt  <= gcnt_d;
    end
  end

  // Next-state: enter CLEAR on clr_i, leave after group 63 is cleared
  always_comb begin
    state_d = state;
    gcnt_d  = gcnt;
    case (state)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          gcnt_d  = '0;
        end
      end
      CLEAR: begin
        gcnt_d = gcnt + 6'd1;
        if (gcnt == 6'd63) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot mask of the group being swept this cycle
  always_comb begin
    clr_grp = '0;
    if (state == CLEAR) clr_grp[gcnt] = 1'b1;
  end

  // clr_i has priority over a write presented in the same cycle
  assign wr_ready_o = (state == IDLE) && !clr_i;
  assign busy_o     = (state == CLEAR);
`else
  logic unused_clr;

  assign unused_clr = clr_i;
  assign clr_grp    = '0;
  assign wr_ready_o = 1'b1;
  assign busy_o     = 1'b0;
`endif

  // Stage 1: capture group one-hot, entry index and data on accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_grp  <= '0;
      s1_idx  <= '0;
      s1_data <= '0;
      s1_v    <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_grp  <= 64'd1 << wr_addr_i[11:6];
        s1_idx  <= wr_addr_i[5:0];
        s1_data <= wr_data_i;
      end
    end
  end

  // Stage 2 commit pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wr_done_o <= 1'b0;
    else         wr_done_o <= s1_v;
  end

  // Array: the sweep wins over a commit landing in the same group and cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) data_o[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (clr_grp[i[11:6]]) begin
          data_o[i] <= '0;
        end else if (s1_v && s1_grp[i[11:6]] && (s1_idx == i[5:0])) begin
          data_o[i] <= s1_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux1to4096_wr_n.sv
// Scoreboard bench for demux1to4096_wr_n: accepted writes push an expected
// (address, data) pair; a monitor pops one on each wr_done_o pulse and checks
// the array. A plain array model of the contents is compared in full at
// quiet points.
module tb_demux1to4096_wr_n;
  localparam int N = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [11:0]   wr_addr_i;
  logic [N-1:0]  wr_data_i;
  logic          wr_done_o;
  logic          clr_i;
  logic          busy_o;
  logic [N-1:0]  data_o [0:4095];

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int n_done = 0;

  logic [N-1:0]    model [0:4095];
  logic [12+N-1:0] sb_q [$];
  logic [12+N-1:0] sb_e;
  logic [11:0]     saddr [4] = '{12'h000, 12'h03F, 12'h040, 12'hFFF};

  demux1to4096_wr_n #(.n(N), .address(12)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .wr_done_o  (wr_done_o),
    .clr_i      (clr_i),
    .busy_o     (busy_o),
    .data_o     (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 4096; i++) begin
      if (data_o[i] !== model[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d entries differ, first 0x%03h got %0h expected %0h",
               name, bad, first, data_o[first], model[first]);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 4096; i++) model[i] = '0;
  endtask

  // Present inputs just after a rising edge; decide acceptance at the falling
  // edge before the edge that samples them.
  task automatic drive(input logic v, input logic [11:0] a, input logic [N-1:0] d, input logic c);
    @(posedge clk_i);
    #1;
    wr_valid_i = v;
    wr_addr_i  = a;
    wr_data_i  = d;
    clr_i      = c;
    @(negedge clk_i);
    if (v && wr_ready_o === 1'b1) begin
      sb_q.push_back({a, d});
      model[a] = d;
      n_acc++;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 12'h000, '0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once
  task automatic reset_now(input string name);
    wr_valid_i = 1'b0;
    clr_i      = 1'b0;
    rst_ni     = 1'b0;
    sb_q.delete();
    n_acc  = 0;
    n_done = 0;
    model_zero();
    #1;
    chk({name, "_done"},  wr_done_o,  0);
    chk({name, "_busy"},  busy_o,     0);
    chk({name, "_ready"}, wr_ready_o, 1);
    check_all({name, "_data"});
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

`ifdef DEMUX_WR_CLEAR_EN
  // Called right after clr_i was presented; busy_o must hold for 64 cycles
  task automatic run_clear(input string name);
    int cnt = 0;
    bit rdy_bad = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 12'h000, '0, 1'b0);
      if (busy_o !== 1'b1) break;
      cnt++;
      if (wr_ready_o !== 1'b0) rdy_bad = 1'b1;
    end
    chk({name, "_busy_len"},    cnt,        64);
    chk({name, "_ready_low"},   rdy_bad,    0);
    chk({name, "_ready_after"}, wr_ready_o, 1);
    model_zero();
  endtask
`endif

  // Monitor: each commit pulse must match the oldest accepted write
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && wr_done_o === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: wr_done_o=1 with no write outstanding, expected 0");
      end else begin
        sb_e = sb_q.pop_front();
        chk("done_data", data_o[sb_e[12+N-1:N]], sb_e[N-1:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0]  a;
    logic [11:0]  last_a;
    logic [N-1:0] d;
    logic         v;
    bit           ok;

    rst_ni     = 1'b0;
    wr_valid_i = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    clr_i      = 1'b0;
    model_zero();
    #12;
    check_all("reset_data");
    chk("reset_done",  wr_done_o,  0);
    chk("reset_busy",  busy_o,     0);
    chk("reset_ready", wr_ready_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single write and its latency
    drive(1'b1, 12'hABC, 4'h5, 1'b0);
    chk("single_ready", wr_ready_o, 1);
    idle(1);
    chk("single_not_yet", data_o[12'hABC], 0);
    chk("single_done_early", wr_done_o, 0);
    idle(2);
    chk("single_done_count", n_done, 1);
    check_all("single_write");

    // Streaming across group boundaries
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, saddr[i], N'(i + 1), 1'b0);
      if (wr_ready_o !== 1'b1) ok = 1'b0;
    end
    idle(3);
    chk("stream_ready", ok, 1);
    chk("stream_done_count", n_done, 5);
    check_all("stream");

    // Same-address burst: last write wins
    drive(1'b1, 12'h123, 4'h7, 1'b0);
    drive(1'b1, 12'h123, 4'h9, 1'b0);
    idle(3);
    chk("burst_last", data_o[12'h123], 9);
    check_all("burst");

    // Reset with a write sitting in stage 1
    drive(1'b1, 12'h200, 4'h7, 1'b0);
    @(posedge clk_i);
    #2;
    reset_now("rst_write");

    // Randomized writes
    last_a = 12'h000;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 4) == 0) ? last_a : 12'($urandom_range(0, 4095));
      d = N'($urandom);
      drive(v, a, d, 1'b0);
      if (v) last_a = a;
    end
    idle(3);
    check_all("random");
    chk("random_done_count", n_done, n_acc);

`ifdef DEMUX_WR_CLEAR_EN
    // Bulk clear of a populated array
    drive(1'b1, 12'h000, 4'hF, 1'b0);
    drive(1'b1, 12'h7FF, 4'hF, 1'b0);
    drive(1'b1, 12'hFFF, 4'hF, 1'b0);
    idle(3);
    drive(1'b0, 12'h000, '0, 1'b1);
    chk("bulk_clr_ready", wr_ready_o, 0);
    run_clear("bulk");
    check_all("bulk_clear");

    // clr_i and a write in the same cycle: clear wins
    drive(1'b1, 12'h055, 4'hA, 1'b1);
    chk("conflict_ready", wr_ready_o, 0);
    run_clear("conflict");
    check_all("conflict");

    // Write accepted one edge before clr_i still commits, then is swept
    drive(1'b1, 12'h010, 4'h6, 1'b0);
    drive(1'b0, 12'h000, '0, 1'b1);
    run_clear("inflight");
    chk("inflight_done_count", n_done, n_acc);
    check_all("inflight");

    // Reset in the middle of a sweep (gcnt about 20)
    drive(1'b1, 12'h3C0, 4'h3, 1'b0);
    idle(2);
    drive(1'b0, 12'h000, '0, 1'b1);
    idle(21);
    chk("midclr_busy_before", busy_o, 1);
    #2;
    reset_now("rst_clear");
`else
    // Without the clear feature clr_i has no effect
    drive(1'b1, 12'h321, 4'hB, 1'b1);
    chk("noclr_ready", wr_ready_o, 1);
    drive(1'b0, 12'h000, '0, 1'b1);
    chk("noclr_busy", busy_o, 0);
    idle(2);
    chk("noclr_busy_later", busy_o, 0);
    check_all("noclr_data");
`endif

    // Normal operation after a reset
    drive(1'b1, 12'h777, 4'hC, 1'b0);
    drive(1'b1, 12'h001, 4'h2, 1'b0);
    idle(3);
    chk("post_reset_done_count", n_done, n_acc);
    check_all("post_reset");

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
